rsa_decrypt_stream: RTL and testbench

- Sequential RSA decryption engine, the receiving end of the encrypt path: computes M = C^d mod n for one ciphertext word per transaction.
- Input is a valid/ready handshake carrying ciphertext plus key (d, n); output is a valid/ready plaintext stream.
- Built from a bit-serial modular reducer and two bit-serial modular multipliers (square-and-multiply, LSB-first exponent), so no wide multipliers are needed.
- Sits downstream of key generation and the encryptor and replaces the combinational decrypt path on the low-power datapath.

---
 rtl/rsa_decrypt_stream.sv | 270 +++++++++++++++++++++++++++
 tb/tb_rsa_decrypt_stream.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_decrypt_stream.sv
// rsa_decrypt_stream: sequential RSA decryption, M = C^d mod n, one word per
// transaction. A bit-serial reducer forms C mod n, then LSB-first
// square-and-multiply runs two interleaved bit-serial modular multipliers.
// No wide multipliers are used.
//
// Optional feature macro: RSA_DEC_EARLY_EXIT_EN
//   When defined, EXP runs only as many steps as d has significant bits.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   ciphertext/key word presented
//   in_ready   engine idle and able to accept
//   in_c       ciphertext C (may be >= n)
//   in_d       private exponent d
//   in_n       modulus n
//   out_valid  result available
//   out_ready  consumer accepts result
//   out_m      decrypted message
//   out_err    result invalid (n == 0), qualified by out_valid
//   busy       high while a word is in flight (LOAD/EXP/OUT)
module rsa_decrypt_stream #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_c,
  input  logic [W-1:0] in_d,
  input  logic [W-1:0] in_n,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_m,
  output logic         out_err,
  output logic         busy
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXP  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Captured operands and datapath registers
  logic [W-1:0]  c_q;       // ciphertext, shifted out MSB first
  logic [W-1:0]  d_q;       // exponent, shifted out LSB first
  logic [W-1:0]  n_q;
  logic          err_q;     // n == 0: datapath held idle
  logic [W-1:0]  r_q;       // reducer remainder
  logic [W-1:0]  base_q;
  logic [W-1:0]  result_q;
  logic [W-1:0]  acc_r;     // result*base accumulator
  logic [W-1:0]  acc_b;     // base*base accumulator
  logic [W-1:0]  mb_q;      // multiplier bits (base), consumed MSB first
  logic [CW-1:0] cyc_q;     // bit counter inside LOAD / an EXP step
  logic [CW-1:0] step_q;    // exponent step counter
  logic [CW-1:0] steps_q;   // number of exponent steps for this word
  logic          prime_q;   // one-cycle EXP entry that loads the multipliers

  // Output register next values
  logic          in_ready_nxt, out_valid_nxt, busy_nxt, out_err_nxt;
  logic [W-1:0]  out_m_nxt;

  // One multiply cycle: acc = 2acc mod n, then optionally acc = (acc + a) mod n.
  // Both operands stay below n, so one conditional subtract per operation is exact.
  function automatic logic [W-1:0] mod_step(input logic [W-1:0] acc,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] n,
                                            input logic         add);
    logic [W:0]   dbl;
    logic [W:0]   sum;
    logic [W-1:0] r;
    dbl = {acc, 1'b0};
    r   = (dbl >= {1'b0, n}) ? dbl[W-1:0] - n : dbl[W-1:0];
    sum = {1'b0, r} + {1'b0, a};
    if (add) begin
      r = (sum >= {1'b0, n}) ? sum[W-1:0] - n : sum[W-1:0];
    end
    return r;
  endfunction

`ifdef RSA_DEC_EARLY_EXIT_EN
  // Index of the highest set bit plus one (0 when d == 0).
  function automatic logic [CW-1:0] sig_bits(input logic [W-1:0] d);
    logic [CW-1:0] k;
    k = '0;
    for (int i = 0; i < W; i++) begin
      if (d[i]) k = CW'(i + 1);
    end
    return k;
  endfunction
`endif

  // Reducer: r = 2r + c_bit, single conditional subtract. The remainder is
  // taken as zero on the first LOAD cycle so it needs no clearing at capture.
  logic [W-1:0] r_in;
  logic [W:0]   red_t;
  logic [W-1:0] red_nxt;
  always_comb begin
    r_in    = (cyc_q == '0) ? '0 : r_q;
    red_t   = {r_in, c_q[W-1]};
    red_nxt = (red_t >= {1'b0, n_q}) ? red_t[W-1:0] - n_q : red_t[W-1:0];
  end

  // Both multipliers share the multiplier bit stream (the base).
  logic [W-1:0] acc_r_nxt, acc_b_nxt;
  always_comb begin
    acc_r_nxt = mod_step(acc_r, result_q, n_q, mb_q[W-1]);
    acc_b_nxt = mod_step(acc_b, base_q,   n_q, mb_q[W-1]);
  end

  logic last_load, step_end, exp_done;
  logic [W-1:0] result_fin;
  always_comb begin
    last_load = (state == LOAD) && (cyc_q == CW'(W - 1));
    step_end  = (state == EXP) && !prime_q && (cyc_q == CW'(W - 1));
    if (prime_q) begin
      exp_done = (state == EXP) && (steps_q == '0);
    end else begin
      exp_done = step_end && (step_q == steps_q - CW'(1));
    end
    // Value result_q takes on the edge that leaves EXP
    if (!prime_q && d_q[0]) begin
      result_fin = acc_r_nxt;
    end else begin
      result_fin = result_q;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = LOAD;
      LOAD:    if (last_load) state_nxt = EXP;
      EXP:     if (exp_done)  state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs
  always_comb begin
    in_ready_nxt  = (state_nxt == IDLE);
    out_valid_nxt = (state_nxt == OUT);
    busy_nxt      = (state_nxt != IDLE);
    out_m_nxt     = out_m;
    out_err_nxt   = out_err;
    if ((state == EXP) && (state_nxt == OUT)) begin
      out_m_nxt   = err_q ? '0 : result_fin;
      out_err_nxt = err_q;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_m     <= '0;
      out_err   <= 1'b0;
    end else begin
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
      out_m     <= out_m_nxt;
      out_err   <= out_err_nxt;
    end
  end

  // Datapath: reducer updates only in LOAD, multipliers only in EXP, and
  // nothing arithmetic moves when n == 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_q      <= '0;
      d_q      <= '0;
      n_q      <= '0;
      err_q    <= 1'b0;
      r_q      <= '0;
      base_q   <= '0;
      result_q <= '0;
      acc_r    <= '0;
      acc_b    <= '0;
      mb_q     <= '0;
      cyc_q    <= '0;
      step_q   <= '0;
      steps_q  <= '0;
      prime_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            c_q   <= in_c;
            d_q   <= in_d;
            n_q   <= in_n;
            err_q <= (in_n == '0);
            cyc_q <= '0;
`ifdef RSA_DEC_EARLY_EXIT_EN
            steps_q <= sig_bits(in_d);
`else
            steps_q <= CW'(W);
`endif
          end
        end
        LOAD: begin
          cyc_q <= cyc_q + CW'(1);
          if (!err_q) begin
            r_q <= red_nxt;
            c_q <= {c_q[W-2:0], 1'b0};
          end
          if (last_load) begin
            cyc_q   <= '0;
            step_q  <= '0;
            prime_q <= 1'b1;
            if (!err_q) begin
              base_q   <= red_nxt;
              result_q <= (n_q == W'(1)) ? '0 : W'(1);
            end
          end
        end
        EXP: begin
          if (prime_q) begin
            prime_q <= 1'b0;
            cyc_q   <= '0;
            if (!err_q) begin
              acc_r <= '0;
              acc_b <= '0;
              mb_q  <= base_q;
            end
          end else begin
            cyc_q <= cyc_q + CW'(1);
            if (!err_q) begin
              acc_r <= acc_r_nxt;
              acc_b <= acc_b_nxt;
              mb_q  <= {mb_q[W-2:0], 1'b0};
            end
            // Step end: commit result (if the d bit is set) and the squared base
            if (step_end) begin
              cyc_q  <= '0;
              step_q <= step_q + CW'(1);
              if (!err_q) begin
                acc_r  <= '0;
                acc_b  <= '0;
                base_q <= acc_b_nxt;
                mb_q   <= acc_b_nxt;
                d_q    <= {1'b0, d_q[W-1:1]};
                if (d_q[0]) result_q <= acc_r_nxt;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_decrypt_stream.sv
// Scoreboard bench for rsa_decrypt_stream: the driver pushes expected
// results from a plain-arithmetic modexp model; a negedge monitor pops and
// compares on every new out_valid, and checks hold behaviour under stall.
module tb_rsa_decrypt_stream;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_c, in_d, in_n;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_m;
  logic         out_err;
  logic         busy;

  rsa_decrypt_stream #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_c(in_c), .in_d(in_d), .in_n(in_n),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_m(out_m), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m;
    bit err;
    int lat;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   bp_mode = 0;   // 0: always ready, 1: random, 2: hold low

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #2;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: square-and-multiply over the exponent bits with ordinary arithmetic.
  function automatic exp_t model(input int c, input int d, input int n, input int acc);
    exp_t   e;
    longint m, b;
    int     k;
    if (n == 0) begin
      e.m = 0;
      e.err = 1'b1;
    end else begin
      m = 1 % n;
      b = c % n;
      for (int i = 0; i < W; i++) begin
        if (((d >> i) & 1) == 1) m = (m * b) % n;
        b = (b * b) % n;
      end
      e.m = int'(m);
      e.err = 1'b0;
    end
    k = W;
`ifdef RSA_DEC_EARLY_EXIT_EN
    k = 0;
    for (int i = 0; i < W; i++) if (((d >> i) & 1) == 1) k = i + 1;
`endif
    e.lat = W * (k + 1) + 1;
    e.acc = acc;
    return e;
  endfunction

  // Monitor
  bit   pv = 1'b0, pe = 1'b0, pr = 1'b0;
  int   pm = 0;
  exp_t got;

  always @(negedge clk) begin
    if (reset) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_m", int'(out_m), pm);
        check("hold_err", int'(out_err), int'(pe));
      end
      if (pv && pr) check("valid_drop_after_ack", int'(out_valid), 0);
      if (out_valid) begin
        check("in_ready_while_out", int'(in_ready), 0);
        if (!pv) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: out_m=%0d with no pending word", out_m);
          end else begin
            got = sb.pop_front();
            check("out_m", int'(out_m), got.m);
            check("out_err", int'(out_err), int'(got.err));
            check("latency", cyc - got.acc, got.lat);
          end
        end
      end
      pv = out_valid;
      pm = int'(out_m);
      pe = out_err;
      pr = out_ready;
    end
  end

  // Present a word; called just after a rising edge.
  task automatic send(input int c, input int d, input int n);
    int t;
    t = 0;
    in_c = W'(c);
    in_d = W'(d);
    in_n = W'(n);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", t);
    end else begin
      last_acc = cyc + 1;
      sb.push_back(model(c, d, n, cyc + 1));
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || !in_ready) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: pending=%0d in_ready=%0d", sb.size(), in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset = 1'b1;
    in_valid = 1'b0;
    in_c = '0;
    in_d = '0;
    in_n = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_m", int'(out_m), 0);
    check("rst_out_err", int'(out_err), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed words
    send(47, 27, 55);  drain();
    send(100, 1, 55);  drain();
    send(12, 0, 55);   drain();
    send(9, 5, 1);     drain();
    send(5, 3, 0);     drain();

    // Back-pressure: hold the result for 10 cycles, then release
    bp_mode = 2;
    send(47, 27, 55);
    t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("bp_valid_seen", int'(out_valid), 1);
    repeat (10) begin
      @(negedge clk);
      check("bp_in_ready_low", int'(in_ready), 0);
      check("bp_busy", int'(busy), 1);
    end
    bp_mode = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("bp_in_ready_after_ack", int'(in_ready), 1);
    check("bp_valid_after_ack", int'(out_valid), 0);
    @(posedge clk);
    #1;
    send(2, 3, 55);    drain();

    // Input stall: keep in_valid high with changing data while busy
    send(30, 7, 55);
    in_valid = 1'b1;
    repeat (20) begin
      in_c = W'($urandom_range(0, (1 << W) - 1));
      in_d = W'($urandom_range(0, (1 << W) - 1));
      @(negedge clk);
      check("stall_in_ready_low", int'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();

    // Reset during EXP, 30 edges after the accept
    send(47, 27, 55);
    while (cyc < last_acc + 29) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out_m", int'(out_m), 0);
    check("abort_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    send(47, 27, 55);  drain();

    // Random words under random back-pressure
    bp_mode = 1;
    repeat (25) begin
      send(int'($urandom_range(0, (1 << W) - 1)),
           int'($urandom_range(0, (1 << W) - 1)),
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1))
                                       : int'($urandom_range(0, (1 << W) - 1)));
    end
    drain();
    bp_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
